// File: rtl/pipe_dbg_pkg.sv
// Shared constants and types for the pipeline debug controller.
package pipe_dbg_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned IDX_W    = 5;

  // Command opcodes
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_DUMP   = 3'd4;
  localparam logic [2:0] OP_SETBP  = 3'd5;
  localparam logic [2:0] OP_CLRBP  = 3'd6;
  localparam logic [2:0] OP_CLRCNT = 3'd7;

  typedef enum logic [2:0] {
    StHalt,
    StRun,
    StStep,
    StDsel,
    StDout
  } dbg_state_e;

endpackage

// File: rtl/pipe_debug_ctrl_if.sv
// Command and register-dump channels between the host and the debug controller.
interface pipe_debug_ctrl_if #(
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [4:0]        dump_idx;

  // Host side
  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, dump_valid, dump_data, dump_idx
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, dump_valid, dump_data, dump_idx
  );

endinterface

// File: rtl/pipe_dbg_dump.sv
// Register-dump sequencer: walks reg_sel over all GPRs and presents each value
// on a valid/ready channel. Alternates a select cycle (capture) and an output
// cycle (wait for handshake).
module pipe_dbg_dump
  import pipe_dbg_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [IDX_W-1:0]  dump_idx,
  output logic              done
);

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  reg_sel_q;
  logic              capture_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  didx_q;
  logic              last;
  logic              hs;

  assign last       = (idx_q == IDX_W'(NREG - 1));
  assign hs         = valid_q & dump_ready;
  assign done       = hs & last;
  assign reg_sel    = reg_sel_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_idx   = didx_q;

  // Sequencing: start -> capture -> wait handshake -> next register or finish
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      reg_sel_q <= '0;
      capture_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      didx_q    <= '0;
    end else if (start) begin
      idx_q     <= '0;
      reg_sel_q <= '0;
      capture_q <= 1'b1;
    end else if (capture_q) begin
      data_q    <= reg_data;
      didx_q    <= idx_q;
      valid_q   <= 1'b1;
      capture_q <= 1'b0;
    end else if (hs) begin
      valid_q <= 1'b0;
      if (!last) begin
        idx_q     <= idx_q + 1'b1;
        reg_sel_q <= idx_q + 1'b1;
        capture_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Run/halt/step controller with PC breakpoint and GPR dump for the pipelined core.
// Optional feature macro: PIPE_DBG_CYCLE_CNT_EN (enables the cpu_en cycle counter
// and the CLRCNT command; otherwise cycle_cnt reads 0 and CLRCNT is a NOP).
module pipe_debug_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_debug_ctrl_if.slave  bus,
  input  logic [DATA_W-1:0] cpu_pc,
  output logic              cpu_en,
  output logic [IDX_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              halted,
  output logic              bp_hit,
  output logic [31:0]       cycle_cnt
);

  dbg_state_e        state_q, state_d;
  logic              bp_en_q;
  logic [DATA_W-1:0] bp_addr_q;
  logic              bp_hit_q;
  logic              skip_q;
  logic              accept;
  logic              match;
  logic              dump_start;
  logic              dump_done;

  assign bus.cmd_ready = (state_q == StHalt) || (state_q == StRun);
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  // skip lets a RUN issued at the breakpoint PC move past it
  assign match  = (state_q == StRun) & bp_en_q & (cpu_pc == bp_addr_q) & ~skip_q;
  assign cpu_en = ((state_q == StRun) & ~match) | (state_q == StStep);
  assign halted = (state_q == StHalt);
  assign bp_hit = bp_hit_q;

  // Next-state decode
  always_comb begin
    state_d    = state_q;
    dump_start = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_RUN:  state_d = StRun;
            OP_STEP: state_d = StStep;
            OP_DUMP: begin
              state_d    = StDsel;
              dump_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (match || (accept && bus.cmd_op == OP_HALT)) state_d = StHalt;
      end
      StStep: state_d = StHalt;
      StDsel: state_d = StDout;
      StDout: begin
        if (bus.dump_valid && bus.dump_ready) state_d = dump_done ? StHalt : StDsel;
      end
      default: state_d = StHalt;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StHalt;
    else     state_q <= state_d;
  end

  // Breakpoint registers, sticky hit flag and RUN skip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      bp_hit_q  <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      if (state_q == StRun) skip_q <= 1'b0;
      if (accept) begin
        case (bus.cmd_op)
          OP_SETBP: begin
            bp_addr_q <= bus.cmd_arg;
            bp_en_q   <= 1'b1;
          end
          OP_CLRBP: bp_en_q <= 1'b0;
          OP_RUN: begin
            bp_hit_q <= 1'b0;
            if (state_q == StHalt) skip_q <= 1'b1;
          end
          OP_STEP: bp_hit_q <= 1'b0;
          default: ;
        endcase
      end
      // A match in the same cycle as a RUN/STEP accept must leave the flag set
      if (match) bp_hit_q <= 1'b1;
    end
  end

`ifdef PIPE_DBG_CYCLE_CNT_EN
  logic [31:0] cnt_q;

  // Count enabled cycles; CLRCNT takes priority over the increment
  always_ff @(posedge clk) begin
    if (rst)                                   cnt_q <= '0;
    else if (accept && bus.cmd_op == OP_CLRCNT) cnt_q <= '0;
    else if (cpu_en)                           cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

  pipe_dbg_dump #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .start      (dump_start),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .dump_valid (bus.dump_valid),
    .dump_ready (bus.dump_ready),
    .dump_data  (bus.dump_data),
    .dump_idx   (bus.dump_idx),
    .done       (dump_done)
  );

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed bench for pipe_debug_ctrl with a simple PC model and register file model.
module tb_pipe_debug_ctrl;
  import pipe_dbg_pkg::*;

`ifdef PIPE_DBG_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] cpu_pc;
  logic        cpu_en;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_cnt;

  pipe_debug_ctrl_if #(.DATA_W(32)) bus ();

  pipe_debug_ctrl #(
    .NREG   (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_pc    (cpu_pc),
    .cpu_en    (cpu_en),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PC advances by 4 on each enabled cycle; rf[i] = i*0x11
  always @(posedge clk) begin
    if (rst)         cpu_pc <= 32'd0;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
  end
  assign reg_data = 32'(reg_sel) * 32'h11;

  // Monitors sampled mid-cycle
  int          en_cnt = 0;
  int          mon_cnt = 0;
  logic [31:0] mon_data [256];
  logic [4:0]  mon_idx  [256];
  always @(negedge clk) begin
    if (cpu_en) en_cnt <= en_cnt + 1;
    if (bus.dump_valid && bus.dump_ready) begin
      mon_data[mon_cnt % 256] <= bus.dump_data;
      mon_idx[mon_cnt % 256]  <= bus.dump_idx;
      mon_cnt <= mon_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_arg   = 32'd0;
  endtask

  task automatic wait_halted(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!bus.dump_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_timeout", {31'd0, bus.dump_valid}, 32'd1);
  endtask

  // Hand-shake nw words one at a time; word stall_w is held for 5 extra cycles
  task automatic take_words(input int nw, input int stall_w);
    for (int w = 0; w < nw; w++) begin
      wait_valid(10);
      if (w == stall_w) begin
        repeat (5) begin
          idle(1);
          chk("stall_valid", {31'd0, bus.dump_valid}, 32'd1);
          chk("stall_idx", 32'(bus.dump_idx), 32'(w));
          chk("stall_data", bus.dump_data, 32'(w) * 32'h11);
          chk("stall_regsel", 32'(reg_sel), 32'(w));
        end
      end
      bus.dump_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.dump_ready = 1'b0;
    end
  endtask

  task automatic chk_words(input int base, input int nw);
    chk("word_count", 32'(mon_cnt - base), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      chk("word_idx", 32'(mon_idx[(base + i) % 256]), 32'(i));
      chk("word_data", mon_data[(base + i) % 256], 32'(i) * 32'h11);
    end
  endtask

  initial begin
    int e0;
    int c0;
    int b0;
    int n;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_NOP;
    bus.cmd_arg    = 32'd0;
    bus.dump_ready = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_regsel", 32'(reg_sel), 32'd0);
    chk("rst_dvalid", {31'd0, bus.dump_valid}, 32'd0);
    chk("rst_ddata", bus.dump_data, 32'd0);
    chk("rst_didx", 32'(bus.dump_idx), 32'd0);
    chk("rst_bphit", {31'd0, bp_hit}, 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);

    // RUN, 20 idle cycles, HALT: 21 enabled cycles
    e0 = en_cnt;
    do_cmd(OP_RUN, 32'd0);
    chk("run_lat", {31'd0, cpu_en}, 32'd1);
    chk("run_halted", {31'd0, halted}, 32'd0);
    idle(20);
    do_cmd(OP_HALT, 32'd0);
    chk("halt_en_cycles", 32'(en_cnt - e0), 32'd21);
    chk("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_cnt", cycle_cnt, CNT_EN ? 32'd21 : 32'd0);

    // Breakpoint at 0x10: stops with that PC unexecuted after 4 enabled cycles
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    do_cmd(OP_SETBP, 32'h10);
    e0 = en_cnt;
    do_cmd(OP_RUN, 32'd0);
    wait_halted(50, n);
    chk("bp_pc", cpu_pc, 32'h10);
    chk("bp_hit", {31'd0, bp_hit}, 32'd1);
    chk("bp_en_cycles", 32'(en_cnt - e0), 32'd4);
    chk("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
    // RUN again leaves the breakpoint PC
    do_cmd(OP_RUN, 32'd0);
    chk("bp_rerun_en", {31'd0, cpu_en}, 32'd1);
    chk("bp_hit_clr", {31'd0, bp_hit}, 32'd0);
    idle(3);
    chk("bp_pass_pc", cpu_pc, 32'h1C);
    chk("bp_pass_halted", {31'd0, halted}, 32'd0);
    do_cmd(OP_HALT, 32'd0);
    chk("bp_halt2", {31'd0, halted}, 32'd1);

    do_cmd(OP_CLRCNT, 32'd0);
    chk("clrcnt", cycle_cnt, 32'd0);

    // Three single-cycle steps
    e0 = en_cnt;
    c0 = int'(cycle_cnt);
    for (int s = 0; s < 3; s++) begin
      do_cmd(OP_STEP, 32'd0);
      chk("step_en", {31'd0, cpu_en}, 32'd1);
      chk("step_halted", {31'd0, halted}, 32'd0);
      chk("step_ready", {31'd0, bus.cmd_ready}, 32'd0);
      idle(1);
      chk("step_back_en", {31'd0, cpu_en}, 32'd0);
      chk("step_back_halted", {31'd0, halted}, 32'd1);
    end
    chk("step_en_cycles", 32'(en_cnt - e0), 32'd3);
    chk("step_cnt", cycle_cnt - 32'(c0), CNT_EN ? 32'd3 : 32'd0);

    // Full dump with dump_ready held high: 64 cycles
    b0 = mon_cnt;
    bus.dump_ready = 1'b1;
    do_cmd(OP_DUMP, 32'd0);
    chk("dump_lat0_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("dump_lat0_regsel", 32'(reg_sel), 32'd0);
    chk("dump_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    idle(1);
    chk("dump_lat1_valid", {31'd0, bus.dump_valid}, 32'd1);
    chk("dump_lat1_idx", 32'(bus.dump_idx), 32'd0);
    wait_halted(200, n);
    chk("dump_cycles", 32'(n + 1), 32'd64);
    bus.dump_ready = 1'b0;
    chk_words(b0, 32);

    // Dump with a 5-cycle stall on word 7
    b0 = mon_cnt;
    do_cmd(OP_DUMP, 32'd0);
    take_words(32, 7);
    wait_halted(10, n);
    chk_words(b0, 32);

    // Reset during output of word 12
    do_cmd(OP_DUMP, 32'd0);
    take_words(12, -1);
    wait_valid(10);
    chk("abort_idx", 32'(bus.dump_idx), 32'd12);
    rst = 1'b1;
    idle(1);
    chk("abort_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("abort_regsel", 32'(reg_sel), 32'd0);
    chk("abort_halted", {31'd0, halted}, 32'd1);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    idle(2);
    chk("abort_stay_valid", {31'd0, bus.dump_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
